// File: rtl/echo_tof_capture_if.sv
// rtl/echo_tof_capture_if.sv - result bus from echo_tof_capture to main control (tof_avg under TOF_AVG4_EN)
interface echo_tof_capture_if #(
    parameter int CNT_W = 20
);
    logic [CNT_W-1:0] tof_count;
    logic             tof_valid;
    logic             tof_timeout;
    logic             busy;
`ifdef TOF_AVG4_EN
    logic [CNT_W-1:0] tof_avg;
`endif

    modport master (
        output tof_count,
        output tof_valid,
        output tof_timeout,
`ifdef TOF_AVG4_EN
        output tof_avg,
`endif
        output busy
    );

    modport slave (
        input tof_count,
        input tof_valid,
        input tof_timeout,
`ifdef TOF_AVG4_EN
        input tof_avg,
`endif
        input busy
    );
endinterface

// File: rtl/echo_tof_capture.sv
// rtl/echo_tof_capture.sv - ultrasonic echo time-of-flight capture; TOF_AVG4_EN adds a 4-result running average
module echo_tof_capture #(
    parameter int CNT_W       = 20,
    parameter int BLANK_CYC   = 27000,
    parameter int TIMEOUT_CYC = 810000,
    parameter int FILT_CYC    = 8
) (
    input  logic                gclk,
    input  logic                rstn,
    input  logic                burst_finish,
    input  logic                echo_in,
    echo_tof_capture_if.master  res
);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_VAL     = CNT_W'(TIMEOUT_CYC);
    localparam logic [7:0]       FILT_LAST  = 8'(FILT_CYC - 1);

    typedef enum logic [1:0] {IDLE, BLANK, LISTEN, DONE} state_t;

    state_t           state, state_next;
    logic             sync1, sync2, bf_q;
    logic [CNT_W-1:0] cnt, run_start;
    logic [7:0]       run;
    logic [CNT_W-1:0] tof_count_q;
    logic             tof_timeout_q;
    logic             trig, echo_low, echo_hit, to_hit;

    assign trig     = burst_finish & ~bf_q;
    assign echo_low = ~sync2;
    assign echo_hit = (state == LISTEN) && echo_low && (run == FILT_LAST);
    assign to_hit   = (state == LISTEN) && (cnt == TO_LAST);

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            bf_q  <= 1'b0;
        end else begin
            sync1 <= echo_in;
            sync2 <= sync1;
            bf_q  <= burst_finish;
        end
    end

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // A new trigger wins over everything, including a same-cycle echo or timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trig) state_next = BLANK;
            BLANK:   if (trig) state_next = BLANK;
                     else if (cnt == BLANK_LAST) state_next = LISTEN;
            LISTEN:  if (trig) state_next = BLANK;
                     else if (echo_hit || to_hit) state_next = DONE;
            DONE:    state_next = trig ? BLANK : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        res.busy      = (state == BLANK) || (state == LISTEN);
        res.tof_valid = (state == DONE);
    end

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            cnt           <= '0;
            run           <= '0;
            run_start     <= '0;
            tof_count_q   <= '0;
            tof_timeout_q <= 1'b0;
        end else begin
            if (trig)
                cnt <= '0;
            else if (state_next == BLANK || state_next == LISTEN)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;

            if (state == LISTEN && !trig && echo_low) run <= run + 1'b1;
            else                                      run <= '0;

            if (state == LISTEN && echo_low && run == 8'd0)
                run_start <= cnt;

            // Result is loaded on entry to DONE so it is stable while tof_valid is high.
            if (state == LISTEN && !trig) begin
                if (echo_hit) begin
                    tof_count_q   <= (run == 8'd0) ? cnt : run_start;
                    tof_timeout_q <= 1'b0;
                end else if (to_hit) begin
                    tof_count_q   <= TO_VAL;
                    tof_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign res.tof_count   = tof_count_q;
    assign res.tof_timeout = tof_timeout_q;

`ifdef TOF_AVG4_EN
    logic [CNT_W-1:0] hist [4];
    logic [CNT_W+1:0] sum;

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else if (state == DONE && !tof_timeout_q) begin
            hist[0] <= tof_count_q;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 4; i++) sum = sum + {2'b00, hist[i]};
    end

    assign res.tof_avg = sum[CNT_W+1:2];
`endif
endmodule

// File: tb/tb_echo_tof_capture.sv
// tb/tb_echo_tof_capture.sv - scoreboard bench for echo_tof_capture (TOF_AVG4_EN checks tof_avg)
module tb_echo_tof_capture;
    localparam int CNT_W = 20;

    logic gclk = 1'b0;
    logic rstn, burst_finish, echo_in;

    echo_tof_capture_if #(.CNT_W(CNT_W)) res ();

    echo_tof_capture #(
        .CNT_W(CNT_W), .BLANK_CYC(100), .TIMEOUT_CYC(1000), .FILT_CYC(4)
    ) dut (
        .gclk(gclk), .rstn(rstn), .burst_finish(burst_finish),
        .echo_in(echo_in), .res(res)
    );

    always #5 gclk = ~gclk;

    typedef struct { int cnt; bit to; } exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int fails = 0;
    int n_valid = 0;
    int nv_mark = 0;
    int rel = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    always @(negedge gclk) begin
        if (res.tof_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_valid: got tof_count %0d with no result expected", res.tof_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("tof_count", res.tof_count, e.cnt);
                chk("tof_timeout", res.tof_timeout, e.to);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge gclk);
            #1;
            rel++;
        end
    endtask

    task automatic trigger(input bit hold = 1'b0);
        burst_finish = 1'b1;
        step();
        rel = 0;
        if (!hold) burst_finish = 1'b0;
    endtask

    // Synchronizer delays echo_in by two cycles: drive low two cycles ahead of target cnt.
    task automatic low_at(input int c, input int len);
        while (rel < c - 2) step();
        echo_in = 1'b0;
        step(len);
        echo_in = 1'b1;
    endtask

    task automatic expect_res(input int c, input bit to);
        exp_t e;
        e.cnt = c;
        e.to  = to;
        exp_q.push_back(e);
        nv_mark = n_valid;
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (n_valid <= nv_mark && k < budget) begin
            step();
            k++;
        end
        if (n_valid <= nv_mark) begin
            checks++;
            fails++;
            $display("FAIL wait_valid: got no tof_valid within %0d cycles, required one", budget);
        end
        step(2);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv0;
        rstn = 1'b0;
        burst_finish = 1'b0;
        echo_in = 1'b1;
        step(3);
        chk("reset_tof_count", res.tof_count, 0);
        chk("reset_tof_valid", res.tof_valid, 0);
        chk("reset_tof_timeout", res.tof_timeout, 0);
        chk("reset_busy", res.busy, 0);
        rstn = 1'b1;
        step(2);

        // Normal echo at 300; burst_finish held high to show a level gives no retrigger.
        expect_res(300, 1'b0);
        trigger(1'b1);
        step(2);
        chk("busy_in_blank", res.busy, 1);
        low_at(300, 10);
        wait_valid(1200);
        burst_finish = 1'b0;
        chk("busy_after_done", res.busy, 0);
        step(2);

        // Blanked low, 3-cycle glitch, then accepted 4-cycle echo.
        expect_res(500, 1'b0);
        trigger();
        low_at(50, 20);
        low_at(400, 3);
        low_at(500, 4);
        wait_valid(1200);

        // Low run straddling the end of blanking.
        expect_res(100, 1'b0);
        trigger();
        low_at(99, 7);
        wait_valid(1200);

        // Timeout, then a good measurement clears tof_timeout.
        expect_res(1000, 1'b1);
        trigger();
        wait_valid(1200);
        expect_res(250, 1'b0);
        trigger();
        low_at(250, 6);
        wait_valid(1200);

        // Restart from LISTEN at cnt 600.
        trigger();
        while (rel < 600) step();
        expect_res(300, 1'b0);
        trigger();
        low_at(300, 10);
        wait_valid(1200);
        step(20);
        chk("restart_single_pulse", exp_q.size(), 0);

        // Async reset mid-LISTEN.
        trigger();
        while (rel < 400) step();
        chk("pre_reset_busy", res.busy, 1);
        rstn = 1'b0;
        #1;
        chk("async_rst_tof_count", res.tof_count, 0);
        chk("async_rst_tof_timeout", res.tof_timeout, 0);
        chk("async_rst_tof_valid", res.tof_valid, 0);
        chk("async_rst_busy", res.busy, 0);
        step(3);
        rstn = 1'b1;
        nv0 = n_valid;
        echo_in = 1'b0;
        step(10);
        echo_in = 1'b1;
        step(20);
        chk("no_valid_without_trig", n_valid, nv0);

`ifdef TOF_AVG4_EN
        begin
            int vals[6] = '{100, 200, 300, 400, 0, 500};
            int avgs[6] = '{25, 75, 150, 250, 250, 350};
            for (int i = 0; i < 6; i++) begin
                if (vals[i] == 0) begin
                    expect_res(1000, 1'b1);
                    trigger();
                end else begin
                    expect_res(vals[i], 1'b0);
                    trigger();
                    low_at(vals[i], 6);
                end
                wait_valid(1200);
                chk("tof_avg", res.tof_avg, avgs[i]);
            end
        end
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
